tile_energy_monitor: RTL and testbench
======================================

Name: tile_energy_monitor

Overview:
Parametrised multi-channel energy integrator for the 50-TOPS tile. It converts per-channel dynamic and leakage power (mW) and clock period (ps) into cumulative energy in fJ. It also produces windowed energy snapshots over a valid/ready handshake and raises an over-budget throttle request. It sits beside neuraedge_tile_50tops and replaces the pass-through energy forwarding used in energy-accuracy harnesses and DVFS control.

Parameters:
NUM_CH, 4, number of power channels (PE clusters/domains), >=1
ACC_W, 64, cumulative accumulator width (fJ)
WIN_W, 48, window energy width (fJ)
WINDOW_CYCLES, 1024, accumulate cycles per window, >=2

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  integrate while high
clear  in  1  synchronous pulse; zero all accumulation state
period_ps  in  16  current clock period in ps; 0 = gated, no accumulation
dyn_power_mw  in  NUM_CH*16  per-channel dynamic power from tile power manager
leak_power_mw  in  NUM_CH*16  per-channel leakage power
ext_dyn_power_mw  in  NUM_CH*16  override; a nonzero channel slice replaces the internal value
ext_leak_power_mw  in  NUM_CH*16  override, same rule
window_budget_fj  in  WIN_W  per-window energy budget; 0 = disabled
ch_sel  in  max(1,$clog2(NUM_CH))  channel readback select
ch_dyn_energy_fj  out  ACC_W  cumulative dynamic energy of ch_sel
ch_leak_energy_fj  out  ACC_W  cumulative leakage energy of ch_sel
total_energy_fj  out  ACC_W  sum over all channels, dynamic plus leakage
snap_valid  out  1  window snapshot available
snap_ready  in  1  consumer accepts snapshot
snap_window_energy_fj  out  WIN_W  energy of completed window
snap_window_idx  out  16  window index, wraps at 65535->0
over_budget  out  1  last completed window exceeded budget (throttle request)
overrun_cnt  out  8  windows lost to unaccepted snapshots, saturating
sat_flag  out  1  sticky; some accumulator saturated
busy  out  1  FSM not IDLE

Behaviour:
- Reset: all accumulators, counters, and outputs are 0. FSM goes to IDLE.
- Per channel, the selected power is ext if nonzero, otherwise internal.
- Stage 1 (registered): e_dyn = P_dyn * period_ps and e_leak = P_leak * period_ps, each 32-bit fJ. Products are forced to 0 when enable=0 or period_ps=0.
- Stage 2 (registered): add the products into the channel accumulators, total_energy_fj, and the window accumulator. Latency: inputs at cycle t appear in the outputs at t+2.
- ACC_W accumulators saturate at all-ones and set sat_flag. The window accumulator saturates at WIN_W all-ones.
- ch_* readback is a combinational mux on the registered accumulators.
- FSM IDLE -> RUN when enable=1. RUN -> IDLE when enable=0 after the pipeline drains (2 cycles). The window counter only advances in RUN on stage-2 valid cycles.
- Window end (counter reaches WINDOW_CYCLES-1): the next cycle latches the window sum (including that cycle's addend) into the snapshot. It sets snap_valid, increments snap_window_idx, updates over_budget = (budget!=0 && sum>budget), and restarts the window accumulator from 0.
- Handshake: snap_valid is held with stable data until a cycle with snap_ready=1; it drops the following cycle.
- If a window ends while snap_valid=1 and snap_ready=0: keep the old snapshot, drop the new one, and increment overrun_cnt (saturating at 255). over_budget still updates. If snap_ready=1 in that same cycle, the new snapshot is loaded instead and snap_valid stays high.
- clear has priority over everything except reset. It zeroes the accumulators, window counter, pipeline, snapshot, snap_valid, over_budget, overrun_cnt and sat_flag. FSM goes to IDLE.
- Reset mid-window discards the partial window; no snapshot is produced.

Optional Feature:
TILE_ENERGY_PEAK_TRACK_EN:
- Defined: adds output peak_window_energy_fj [WIN_W]. It holds the maximum completed-window energy since reset/clear and is updated at each window end, including dropped (overrun) windows.
- Undefined: the port and its logic are absent.

Decomposition:
- Package tile_energy_pkg: default widths (ACC_W, WIN_W, power/period width 16, product width 32), saturation-add function, FSM state enum {IDLE, RUN, DRAIN}.
- Sub-module tile_energy_ch_acc, one instance per channel: override select, multiply, saturating dyn/leak accumulators.

Test Plan:
- NUM_CH=2, period_ps=1000, ch0 dyn=100 mW, others 0, enable for 10 cycles -> ch0 dyn = 1,000,000 fJ and total = 1,000,000 fJ; first nonzero output 2 cycles after enable.
- ch0 dyn=100, ext_dyn=250 -> per-cycle increment 250,000 fJ; ext=0 reverts to 100,000.
- WINDOW_CYCLES=4, ch0 dyn=100 and leak=10, budget=400,000 -> snap_valid with 440,000, idx=1, over_budget=1; budget=500,000 -> over_budget=0.
- Hold snap_ready=0 across 3 windows -> first snapshot retained, overrun_cnt=2; then snap_ready=1 -> snap_valid drops next cycle.
- Preload a channel accumulator near 2^64-1 (via force), large power -> saturates at all-ones and sat_flag=1; then clear -> all zero, IDLE.
- period_ps=0 with enable=1 -> no accumulation and window counter still advances; assert reset mid-window -> all outputs 0 and no snapshot.

Source files
------------

// File: rtl/tile_energy_pkg.sv
// Shared widths, FSM state encoding and the saturating adder for the tile energy monitor.
// Optional peak tracking in the top is enabled by defining TILE_ENERGY_PEAK_TRACK_EN.
package tile_energy_pkg;

    localparam int unsigned ACC_W_DEF = 64;
    localparam int unsigned WIN_W_DEF = 48;
    localparam int unsigned PWR_W     = 16;
    localparam int unsigned PROD_W    = 32;
    // Widest accumulator the shared adder supports
    localparam int unsigned SAT_W     = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Adds a+b and clamps to the all-ones value of a w-bit field (w <= SAT_W).
    // Bit SAT_W of the result flags that clamping occurred.
    function automatic logic [SAT_W:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int unsigned      w
    );
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = {1'b0, {SAT_W{1'b1}}} >> (SAT_W - w);
        if (sum > lim) begin
            return {1'b1, lim[SAT_W-1:0]};
        end
        return {1'b0, sum[SAT_W-1:0]};
    endfunction

endpackage

// File: rtl/tile_energy_ch_acc.sv
// One power channel: override select, power x period product (stage 1) and
// saturating dynamic/leakage energy accumulators (stage 2).
module tile_energy_ch_acc
    import tile_energy_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              gate,
    input  logic [PWR_W-1:0]  period_ps,
    input  logic [PWR_W-1:0]  dyn_mw,
    input  logic [PWR_W-1:0]  leak_mw,
    input  logic [PWR_W-1:0]  ext_dyn_mw,
    input  logic [PWR_W-1:0]  ext_leak_mw,
    output logic [PROD_W-1:0] e_dyn,
    output logic [PROD_W-1:0] e_leak,
    output logic [ACC_W-1:0]  dyn_acc,
    output logic [ACC_W-1:0]  leak_acc,
    output logic              sat_hit
);

    logic [PWR_W-1:0] dyn_sel;
    logic [PWR_W-1:0] leak_sel;
    logic [SAT_W:0]   dyn_sum;
    logic [SAT_W:0]   leak_sum;

    always_comb begin
        dyn_sel  = (ext_dyn_mw  != '0) ? ext_dyn_mw  : dyn_mw;
        leak_sel = (ext_leak_mw != '0) ? ext_leak_mw : leak_mw;
        dyn_sum  = sat_add(SAT_W'(dyn_acc),  SAT_W'(e_dyn),  ACC_W);
        leak_sum = sat_add(SAT_W'(leak_acc), SAT_W'(e_leak), ACC_W);
        sat_hit  = dyn_sum[SAT_W] | leak_sum[SAT_W];
    end

    // Stage 1: products are zero whenever integration is gated off
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_dyn  <= '0;
            e_leak <= '0;
        end else if (clear || !gate) begin
            e_dyn  <= '0;
            e_leak <= '0;
        end else begin
            e_dyn  <= PROD_W'(dyn_sel)  * PROD_W'(period_ps);
            e_leak <= PROD_W'(leak_sel) * PROD_W'(period_ps);
        end
    end

    // Stage 2: adding a zero product is harmless, so no separate valid gating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dyn_acc  <= '0;
            leak_acc <= '0;
        end else if (clear) begin
            dyn_acc  <= '0;
            leak_acc <= '0;
        end else begin
            dyn_acc  <= ACC_W'(dyn_sum);
            leak_acc <= ACC_W'(leak_sum);
        end
    end

endmodule

// File: rtl/tile_energy_monitor.sv
// Multi-channel energy integrator with windowed snapshots and over-budget throttle request.
// Define TILE_ENERGY_PEAK_TRACK_EN to add the peak_window_energy_fj output.
module tile_energy_monitor
    import tile_energy_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned ACC_W         = ACC_W_DEF,
    parameter int unsigned WIN_W         = WIN_W_DEF,
    parameter int unsigned WINDOW_CYCLES = 1024,
    localparam int unsigned SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [PWR_W-1:0]          period_ps,
    input  logic [NUM_CH*PWR_W-1:0]   dyn_power_mw,
    input  logic [NUM_CH*PWR_W-1:0]   leak_power_mw,
    input  logic [NUM_CH*PWR_W-1:0]   ext_dyn_power_mw,
    input  logic [NUM_CH*PWR_W-1:0]   ext_leak_power_mw,
    input  logic [WIN_W-1:0]          window_budget_fj,
    input  logic [SEL_W-1:0]          ch_sel,
    output logic [ACC_W-1:0]          ch_dyn_energy_fj,
    output logic [ACC_W-1:0]          ch_leak_energy_fj,
    output logic [ACC_W-1:0]          total_energy_fj,
    output logic                      snap_valid,
    input  logic                      snap_ready,
    output logic [WIN_W-1:0]          snap_window_energy_fj,
    output logic [15:0]               snap_window_idx,
    output logic                      over_budget,
`ifdef TILE_ENERGY_PEAK_TRACK_EN
    output logic [WIN_W-1:0]          peak_window_energy_fj,
`endif
    output logic [7:0]                overrun_cnt,
    output logic                      sat_flag,
    output logic                      busy
);

    localparam int unsigned CNT_W = $clog2(WINDOW_CYCLES);
    localparam int unsigned ADD_W = PROD_W + $clog2(2 * NUM_CH) + 1;

    logic [PROD_W-1:0] e_dyn    [NUM_CH];
    logic [PROD_W-1:0] e_leak   [NUM_CH];
    logic [ACC_W-1:0]  dyn_acc  [NUM_CH];
    logic [ACC_W-1:0]  leak_acc [NUM_CH];
    logic [NUM_CH-1:0] ch_sat;
    logic              gate;

    assign gate = enable && (period_ps != '0);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tile_energy_ch_acc #(
            .ACC_W(ACC_W)
        ) u_acc (
            .clk         (clk),
            .reset       (reset),
            .clear       (clear),
            .gate        (gate),
            .period_ps   (period_ps),
            .dyn_mw      (dyn_power_mw[i*PWR_W +: PWR_W]),
            .leak_mw     (leak_power_mw[i*PWR_W +: PWR_W]),
            .ext_dyn_mw  (ext_dyn_power_mw[i*PWR_W +: PWR_W]),
            .ext_leak_mw (ext_leak_power_mw[i*PWR_W +: PWR_W]),
            .e_dyn       (e_dyn[i]),
            .e_leak      (e_leak[i]),
            .dyn_acc     (dyn_acc[i]),
            .leak_acc    (leak_acc[i]),
            .sat_hit     (ch_sat[i])
        );
    end

    always_comb begin
        ch_dyn_energy_fj  = '0;
        ch_leak_energy_fj = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (SEL_W'(i) == ch_sel) begin
                ch_dyn_energy_fj  = dyn_acc[i];
                ch_leak_energy_fj = leak_acc[i];
            end
        end
    end

    // Stage-2 addend shared by the total and window accumulators
    logic [ADD_W-1:0] addend;
    always_comb begin
        addend = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            addend += ADD_W'(e_dyn[i]) + ADD_W'(e_leak[i]);
        end
    end

    // FSM
    state_t state;
    state_t state_next;
    logic   drain_cnt;
    logic   run_active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == DRAIN) && (state_next == DRAIN);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (!enable) state_next = DRAIN;
            DRAIN: begin
                if (enable)         state_next = RUN;
                else if (drain_cnt) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        run_active = (state == RUN);
    end

    // Window and snapshot datapath
    logic             s1_valid;
    logic [CNT_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_acc;
    logic [15:0]      win_idx;
    logic [SAT_W:0]   tot_sum;
    logic [SAT_W:0]   win_sum;
    logic [WIN_W-1:0] win_val;
    logic             cnt_adv;
    logic             win_end;
    logic             win_over;
    logic             load;

    always_comb begin
        tot_sum  = sat_add(SAT_W'(total_energy_fj), SAT_W'(addend), ACC_W);
        win_sum  = sat_add(SAT_W'(win_acc), SAT_W'(addend), WIN_W);
        win_val  = WIN_W'(win_sum);
        cnt_adv  = run_active && s1_valid;
        win_end  = cnt_adv && (win_cnt == CNT_W'(WINDOW_CYCLES - 1));
        win_over = (window_budget_fj != '0) && (win_val > window_budget_fj);
        // A pending unaccepted snapshot blocks the load unless it is being accepted now
        load     = win_end && (!snap_valid || snap_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid              <= 1'b0;
            total_energy_fj       <= '0;
            sat_flag              <= 1'b0;
            win_cnt               <= '0;
            win_acc               <= '0;
            win_idx               <= '0;
            over_budget           <= 1'b0;
            overrun_cnt           <= '0;
            snap_valid            <= 1'b0;
            snap_window_energy_fj <= '0;
            snap_window_idx       <= '0;
        end else if (clear) begin
            s1_valid              <= 1'b0;
            total_energy_fj       <= '0;
            sat_flag              <= 1'b0;
            win_cnt               <= '0;
            win_acc               <= '0;
            win_idx               <= '0;
            over_budget           <= 1'b0;
            overrun_cnt           <= '0;
            snap_valid            <= 1'b0;
            snap_window_energy_fj <= '0;
            snap_window_idx       <= '0;
        end else begin
            s1_valid        <= enable;
            total_energy_fj <= ACC_W'(tot_sum);
            sat_flag        <= sat_flag | tot_sum[SAT_W] | (|ch_sat);
            win_acc         <= win_end ? '0 : win_val;
            if (cnt_adv) begin
                win_cnt <= win_end ? '0 : win_cnt + 1'b1;
            end
            if (win_end) begin
                win_idx     <= win_idx + 16'd1;
                over_budget <= win_over;
                if (!load && overrun_cnt != 8'hFF) begin
                    overrun_cnt <= overrun_cnt + 8'd1;
                end
            end
            if (load) begin
                snap_valid            <= 1'b1;
                snap_window_energy_fj <= win_val;
                snap_window_idx       <= win_idx + 16'd1;
            end else if (snap_valid && snap_ready) begin
                snap_valid <= 1'b0;
            end
        end
    end

`ifdef TILE_ENERGY_PEAK_TRACK_EN
    // Dropped windows still count toward the peak
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_window_energy_fj <= '0;
        end else if (clear) begin
            peak_window_energy_fj <= '0;
        end else if (win_end && (win_val > peak_window_energy_fj)) begin
            peak_window_energy_fj <= win_val;
        end
    end
`endif

endmodule

// File: tb/tb_tile_energy_monitor.sv
// Directed self-checking bench for tile_energy_monitor (2 channels, 4-cycle windows, 40-bit accumulators).
module tb_tile_energy_monitor;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned ACC_W  = 40;
    localparam int unsigned WIN_W  = 48;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    logic                  clear;
    logic [15:0]           period_ps;
    logic [NUM_CH*16-1:0]  dyn_power_mw;
    logic [NUM_CH*16-1:0]  leak_power_mw;
    logic [NUM_CH*16-1:0]  ext_dyn_power_mw;
    logic [NUM_CH*16-1:0]  ext_leak_power_mw;
    logic [WIN_W-1:0]      window_budget_fj;
    logic [0:0]            ch_sel;
    logic [ACC_W-1:0]      ch_dyn_energy_fj;
    logic [ACC_W-1:0]      ch_leak_energy_fj;
    logic [ACC_W-1:0]      total_energy_fj;
    logic                  snap_valid;
    logic                  snap_ready;
    logic [WIN_W-1:0]      snap_window_energy_fj;
    logic [15:0]           snap_window_idx;
    logic                  over_budget;
    logic [7:0]            overrun_cnt;
    logic                  sat_flag;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] ACC_ONES = 64'h0000_00FF_FFFF_FFFF;

    tile_energy_monitor #(
        .NUM_CH(NUM_CH),
        .ACC_W(ACC_W),
        .WIN_W(WIN_W),
        .WINDOW_CYCLES(4)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .enable                (enable),
        .clear                 (clear),
        .period_ps             (period_ps),
        .dyn_power_mw          (dyn_power_mw),
        .leak_power_mw         (leak_power_mw),
        .ext_dyn_power_mw      (ext_dyn_power_mw),
        .ext_leak_power_mw     (ext_leak_power_mw),
        .window_budget_fj      (window_budget_fj),
        .ch_sel                (ch_sel),
        .ch_dyn_energy_fj      (ch_dyn_energy_fj),
        .ch_leak_energy_fj     (ch_leak_energy_fj),
        .total_energy_fj       (total_energy_fj),
        .snap_valid            (snap_valid),
        .snap_ready            (snap_ready),
        .snap_window_energy_fj (snap_window_energy_fj),
        .snap_window_idx       (snap_window_idx),
        .over_budget           (over_budget),
        .overrun_cnt           (overrun_cnt),
        .sat_flag              (sat_flag),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        enable            = 1'b0;
        clear             = 1'b0;
        period_ps         = '0;
        dyn_power_mw      = '0;
        leak_power_mw     = '0;
        ext_dyn_power_mw  = '0;
        ext_leak_power_mw = '0;
        window_budget_fj  = '0;
        ch_sel            = 1'b0;
        snap_ready        = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_total",    64'(total_energy_fj), 64'd0);
        chk("rst_ch_dyn",   64'(ch_dyn_energy_fj), 64'd0);
        chk("rst_valid",    64'(snap_valid), 64'd0);
        chk("rst_idx",      64'(snap_window_idx), 64'd0);
        chk("rst_over",     64'(over_budget), 64'd0);
        chk("rst_overrun",  64'(overrun_cnt), 64'd0);
        chk("rst_sat",      64'(sat_flag), 64'd0);
        chk("rst_busy",     64'(busy), 64'd0);
        reset = 1'b0;
        tick();

        // Basic integration: 100 mW x 1000 ps for 10 cycles, 2-cycle latency
        period_ps    = 16'd1000;
        dyn_power_mw = 32'd100;
        snap_ready   = 1'b1;
        enable       = 1'b1;
        tick();
        chk("lat_t1_dyn",   64'(ch_dyn_energy_fj), 64'd0);
        chk("lat_t1_busy",  64'(busy), 64'd1);
        tick();
        chk("lat_t2_dyn",   64'(ch_dyn_energy_fj), 64'd100000);
        repeat (8) tick();
        enable = 1'b0;
        repeat (2) tick();
        chk("t1_ch0_dyn",   64'(ch_dyn_energy_fj), 64'd1000000);
        chk("t1_ch0_leak",  64'(ch_leak_energy_fj), 64'd0);
        chk("t1_total",     64'(total_energy_fj), 64'd1000000);
        chk("t1_drain_busy", 64'(busy), 64'd1);
        ch_sel = 1'b1;
        #1;
        chk("t1_ch1_dyn",   64'(ch_dyn_energy_fj), 64'd0);
        ch_sel = 1'b0;
        tick();
        chk("t1_idle_busy", 64'(busy), 64'd0);
        pulse_clear();
        chk("clr1_total",   64'(total_energy_fj), 64'd0);
        chk("clr1_ch_dyn",  64'(ch_dyn_energy_fj), 64'd0);

        // External override replaces, then reverts to, the internal value
        ext_dyn_power_mw = 32'd250;
        enable           = 1'b1;
        repeat (2) tick();
        chk("ovr_first",    64'(ch_dyn_energy_fj), 64'd250000);
        ext_dyn_power_mw = '0;
        tick();
        chk("ovr_second",   64'(ch_dyn_energy_fj), 64'd500000);
        tick();
        chk("ovr_revert",   64'(ch_dyn_energy_fj), 64'd600000);
        chk("ovr_total",    64'(total_energy_fj), 64'd600000);
        enable = 1'b0;
        repeat (4) tick();
        pulse_clear();

        // Windows: 110,000 fJ per cycle, 4 cycles per window
        leak_power_mw    = 32'd10;
        window_budget_fj = 48'd400000;
        snap_ready       = 1'b0;
        enable           = 1'b1;
        repeat (4) tick();
        chk("w1_not_yet",   64'(snap_valid), 64'd0);
        tick();
        chk("w1_valid",     64'(snap_valid), 64'd1);
        chk("w1_energy",    64'(snap_window_energy_fj), 64'd440000);
        chk("w1_idx",       64'(snap_window_idx), 64'd1);
        chk("w1_over",      64'(over_budget), 64'd1);
        snap_ready       = 1'b1;
        window_budget_fj = 48'd500000;
        tick();
        chk("w1_drop",      64'(snap_valid), 64'd0);
        snap_ready = 1'b0;
        repeat (3) tick();
        chk("w2_valid",     64'(snap_valid), 64'd1);
        chk("w2_energy",    64'(snap_window_energy_fj), 64'd440000);
        chk("w2_idx",       64'(snap_window_idx), 64'd2);
        chk("w2_over",      64'(over_budget), 64'd0);
        window_budget_fj = 48'd400000;
        repeat (4) tick();
        chk("w3_overrun",   64'(overrun_cnt), 64'd1);
        chk("w3_over",      64'(over_budget), 64'd1);
        chk("w3_idx_kept",  64'(snap_window_idx), 64'd2);
        repeat (4) tick();
        chk("w4_overrun",   64'(overrun_cnt), 64'd2);
        chk("w4_idx_kept",  64'(snap_window_idx), 64'd2);
        chk("w4_valid",     64'(snap_valid), 64'd1);
        snap_ready = 1'b1;
        tick();
        chk("w4_accept",    64'(snap_valid), 64'd0);
        snap_ready = 1'b0;
        repeat (3) tick();
        chk("w5_valid",     64'(snap_valid), 64'd1);
        chk("w5_idx",       64'(snap_window_idx), 64'd5);
        repeat (3) tick();
        snap_ready = 1'b1;
        tick();
        chk("w6_same_cyc_valid", 64'(snap_valid), 64'd1);
        chk("w6_same_cyc_idx",   64'(snap_window_idx), 64'd6);
        chk("w6_overrun",        64'(overrun_cnt), 64'd2);
        enable = 1'b0;
        repeat (4) tick();
        pulse_clear();

        // Saturation of the 40-bit accumulators
        period_ps     = 16'hFFFF;
        dyn_power_mw  = 32'hFFFF_FFFF;
        leak_power_mw = 32'hFFFF_FFFF;
        enable        = 1'b1;
        repeat (20) tick();
        chk("sat_early",    64'(sat_flag), 64'd0);
        repeat (280) tick();
        chk("sat_ch_dyn",   64'(ch_dyn_energy_fj), ACC_ONES);
        chk("sat_ch_leak",  64'(ch_leak_energy_fj), ACC_ONES);
        chk("sat_total",    64'(total_energy_fj), ACC_ONES);
        chk("sat_flag",     64'(sat_flag), 64'd1);
        enable = 1'b0;
        pulse_clear();
        chk("clr2_ch_dyn",  64'(ch_dyn_energy_fj), 64'd0);
        chk("clr2_total",   64'(total_energy_fj), 64'd0);
        chk("clr2_sat",     64'(sat_flag), 64'd0);
        chk("clr2_busy",    64'(busy), 64'd0);
        tick();
        chk("clr2_flushed", 64'(total_energy_fj), 64'd0);

        // Gated clock: window counter advances with no accumulation
        period_ps     = 16'd0;
        dyn_power_mw  = 32'd100;
        leak_power_mw = '0;
        snap_ready    = 1'b0;
        enable        = 1'b1;
        repeat (5) tick();
        chk("gate_valid",   64'(snap_valid), 64'd1);
        chk("gate_energy",  64'(snap_window_energy_fj), 64'd0);
        chk("gate_idx",     64'(snap_window_idx), 64'd1);
        chk("gate_total",   64'(total_energy_fj), 64'd0);
        chk("gate_over",    64'(over_budget), 64'd0);
        period_ps  = 16'd1000;
        snap_ready = 1'b1;
        repeat (2) tick();
        chk("mid_total",    64'(total_energy_fj), 64'd100000);

        // Asynchronous reset mid-window
        #2;
        reset = 1'b1;
        #1;
        chk("arst_total",   64'(total_energy_fj), 64'd0);
        chk("arst_valid",   64'(snap_valid), 64'd0);
        chk("arst_idx",     64'(snap_window_idx), 64'd0);
        chk("arst_busy",    64'(busy), 64'd0);
        enable = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (6) tick();
        chk("post_rst_valid", 64'(snap_valid), 64'd0);
        chk("post_rst_total", 64'(total_energy_fj), 64'd0);
        chk("post_rst_idx",   64'(snap_window_idx), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
